// File: rtl/ahb_pkg.sv
// Shared AHB encodings plus burst beat-count and wrap-mask helpers.
// Combinational helpers only; no latency, no flow control.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Undefined-length INCR is issued as a single beat.
  function automatic logic [4:0] beat_count(input logic [2:0] burst);
    case (burst)
      HBURST_SINGLE, HBURST_INCR:  beat_count = 5'd1;
      HBURST_WRAP4, HBURST_INCR4:  beat_count = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  beat_count = 5'd8;
      default:                     beat_count = 5'd16;
    endcase
  endfunction

  // Low address bits that wrap; zero for non-wrapping bursts.
  function automatic logic [7:0] wrap_mask(input logic [2:0] burst, input logic [2:0] size);
    logic [7:0] span;
    span = 8'(beat_count(burst)) << size;
    case (burst)
      HBURST_WRAP4, HBURST_WRAP8, HBURST_WRAP16: wrap_mask = span - 8'd1;
      default:                                   wrap_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Next beat address: plain increment, or wrap within the burst-sized window.
// Purely combinational; no flow control.
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [2:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    incr = ADDR_WIDTH'(1) << size;
    sum  = addr + incr;
    mask = ADDR_WIDTH'(wrap_mask(burst, size));
    if (mask == '0) next_addr = sum;
    else            next_addr = (addr & ~mask) | (sum & mask);
  end

endmodule

// File: rtl/ahb_burst_manager.sv
// AHB-Lite master issuing one command as a SINGLE/INCRx/WRAPx burst; data phase lags address by one accepted cycle.
// Write beats stall the bus with BUSY/IDLE when wr_valid is low; read beats have no backpressure.
module ahb_burst_manager #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done_valid,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [1:0]            HTRANS,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);
  import ahb_pkg::*;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DRAIN, ST_ERR} state_t;

  localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;

  state_t                state, state_nxt;
  logic                  rst_done;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [4:0]            beats_left;
  logic                  first_q;
  logic                  dp_vld, dp_write, dp_last;
  logic                  err_hit, accept, beat_rdy;
  logic [1:0]            htrans;

  ahb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (HADDR),
    .size      (HSIZE),
    .burst     (HBURST),
    .next_addr (next_addr)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    htrans     = HTRANS_IDLE;
    beat_rdy   = 1'b0;
    accept     = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    cmd_ready  = (state == ST_IDLE) && rst_done;
    err_hit    = HRESP && !HREADY && (state == ST_ADDR || state == ST_DRAIN);
    case (state)
      ST_IDLE: if (cmd_valid && cmd_ready) state_nxt = ST_ADDR;
      ST_ADDR: begin
        beat_rdy = !HWRITE || wr_valid;
        if (beat_rdy)     htrans = first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
        else if (!first_q) htrans = HTRANS_BUSY;
        accept = beat_rdy && HREADY;
        if (accept && beats_left == 5'd1) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (HREADY) begin
        state_nxt  = ST_IDLE;
        done_valid = 1'b1;
      end
      default: if (HREADY) begin
        state_nxt  = ST_IDLE;
        done_valid = 1'b1;
        done_err   = 1'b1;
      end
    endcase
    // First ERROR cycle: pull the bus to IDLE immediately and drop the rest of the burst.
    if (err_hit) begin
      state_nxt = ST_ERR;
      htrans    = HTRANS_IDLE;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rst_done   <= 1'b0;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= '0;
      HBURST     <= '0;
      HWDATA     <= '0;
      beats_left <= '0;
      first_q    <= 1'b0;
      dp_vld     <= 1'b0;
      dp_write   <= 1'b0;
      dp_last    <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (cmd_valid && cmd_ready) begin
        HADDR      <= cmd_addr;
        HWRITE     <= cmd_write;
        HSIZE      <= (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
        HBURST     <= cmd_burst;
        beats_left <= beat_count(cmd_burst);
        first_q    <= 1'b1;
      end
      if (accept) begin
        if (beats_left != 5'd1) HADDR <= next_addr;
        beats_left <= beats_left - 5'd1;
        first_q    <= 1'b0;
        if (HWRITE) HWDATA <= wr_data;
      end
      if (err_hit) begin
        dp_vld <= 1'b0;
      end else if (HREADY) begin
        dp_vld   <= accept;
        dp_write <= HWRITE;
        dp_last  <= (beats_left == 5'd1);
      end
    end
  end

  assign HTRANS    = htrans;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign wr_ready  = accept && HWRITE;
  assign rd_valid  = dp_vld && !dp_write && HREADY && !HRESP;
  assign rd_last   = rd_valid && dp_last;
  assign rd_data   = HRDATA;

endmodule
